// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, word geometry and the error read-data value.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Read data returned for stores and for any rejected access
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed DEPTH x 32 storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] windex,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] rindex,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[windex] <= wdata;
        end
    end

    // Indices past DEPTH only occur for non-power-of-two depths
    assign rdata = (32'(rindex) < 32'(DEPTH)) ? mem_q[rindex] : 32'h0;

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder: request accepted in IDLE, LATENCY wait cycles, one-cycle ready pulse.
// Request fields are captured on acceptance; stores commit on the RESP edge unless flagged as errors.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err
);

    localparam int         IW     = idx_width(DEPTH);
    localparam int         LSB    = $clog2(WORD_BYTES);
    localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, wdata_q;
    logic        rd_q, wr_q, req_err_q;

    logic          accept;
    logic          go_resp;
    logic [31:0]   src_addr;
    logic          src_rd, src_wr, src_err;
    logic [IW-1:0] src_index;
    logic [31:0]   rdata;

    // In IDLE the live request is decoded so LATENCY=0 can respond without a capture cycle
    assign src_addr  = (state_q == IDLE) ? addr     : addr_q;
    assign src_rd    = (state_q == IDLE) ? memread  : rd_q;
    assign src_wr    = (state_q == IDLE) ? memwrite : wr_q;
    assign src_index = src_addr[IW+LSB-1:LSB];
    assign src_err   = (src_rd & src_wr)
                     | (src_addr[LSB-1:0] != '0)
                     | (32'(src_index) >= 32'(DEPTH))
                     | ((src_addr >> (IW + LSB)) != 32'h0);

    assign accept = (state_q == IDLE) & (memread | memwrite);

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk    (clk),
        .we     ((state_q == RESP) & wr_q & ~req_err_q),
        .windex (src_index),
        .wdata  (wdata_q),
        .rindex (src_index),
        .rdata  (rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        err_d      = err_q;
        go_resp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end else begin
                        go_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            state_d    = RESP;
            err_d      = src_err;
            readdata_d = (!src_err && src_rd) ? rdata : ERR_RDATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            readdata_q <= 32'h0;
            err_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            req_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
            if (accept) begin
                addr_q    <= addr;
                wdata_q   <= writedata;
                rd_q      <= memread;
                wr_q      <= memwrite;
                req_err_q <= src_err;
            end
        end
    end

    assign ready    = (state_q == RESP);
    assign readdata = readdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 5) against a word-array reference model.
// Directed cases first, then randomized transactions.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr [3];
    logic        mw [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [31:0] rd [3];
    logic        rdy [3];
    logic        er [3];

    int LAT [3] = '{2, 0, 5};

    logic [31:0] mm [3][64];
    bit          kn [3][64];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .memread(mr[0]), .memwrite(mw[0]), .addr(ad[0]),
        .writedata(wd[0]), .readdata(rd[0]), .ready(rdy[0]), .err(er[0]));

    dmem_responder #(.DEPTH(64), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset), .memread(mr[1]), .memwrite(mw[1]), .addr(ad[1]),
        .writedata(wd[1]), .readdata(rd[1]), .ready(rdy[1]), .err(er[1]));

    dmem_responder #(.DEPTH(64), .LATENCY(5)) u_lat5 (
        .clk(clk), .reset(reset), .memread(mr[2]), .memwrite(mw[2]), .addr(ad[2]),
        .writedata(wd[2]), .readdata(rd[2]), .ready(rdy[2]), .err(er[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full request on instance k; checks the ready pulse position and the response
    task automatic txn(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit hold, input string tag);
        bit          err_e;
        bit          chk_data;
        logic [31:0] rd_e;
        int          idx;
        err_e    = (r && w) || (a[1:0] != 2'b00) || (a[31:8] != 24'h0);
        idx      = int'(a[7:2]);
        rd_e     = 32'h0;
        chk_data = 1'b1;
        if (!err_e && r) begin
            rd_e     = mm[k][idx];
            chk_data = kn[k][idx];
        end
        @(negedge clk);
        mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
        @(posedge clk); #1;
        if (!hold) begin
            mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = $urandom; wd[k] = $urandom;
        end
        for (int n = 0; n <= LAT[k] + 1; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                if (!hold) begin
                    ad[k] = $urandom; wd[k] = $urandom;
                end
            end
            chk({tag, "_ready"}, 32'(rdy[k]), 32'(n == LAT[k]));
            if (n >= LAT[k]) begin
                chk({tag, "_err"}, 32'(er[k]), 32'(err_e));
                if (chk_data) chk({tag, "_rdata"}, rd[k], rd_e);
            end
        end
        if (hold) begin
            mr[k] = 1'b0; mw[k] = 1'b0;
        end
        if (!err_e && w) begin
            mm[k][idx] = d;
            kn[k][idx] = 1'b1;
        end
    endtask

    initial begin
        int          k;
        int          sel;
        bit          r, w, hold;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = 32'h0; wd[i] = 32'h0;
            for (int j = 0; j < 64; j++) kn[i][j] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 32'(rdy[i]), 32'h0);
            chk("reset_err", 32'(er[i]), 32'h0);
            chk("reset_rdata", rd[i], 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) chk("idle_ready", 32'(rdy[i]), 32'h0);
        end

        txn(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, "store_10");
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "load_10");

        // Asynchronous reset clears held read data without waiting for an edge
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async_reset_rdata", rd[0], 32'h0);
        chk("async_reset_ready", 32'(rdy[0]), 32'h0);
        chk("async_reset_err", 32'(er[0]), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        txn(0, 1'b0, 1'b1, 32'h00, 32'h1111_1111, 1'b0, "store_00");
        txn(0, 1'b0, 1'b1, 32'h20, 32'h0000_1234, 1'b0, "capture_store_20");
        txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, "held_load_20");

        txn(0, 1'b0, 1'b1, 32'h12, 32'hFFFF_0000, 1'b0, "err_misaligned");
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "after_misaligned");
        txn(0, 1'b0, 1'b1, 32'h100, 32'h0000_0077, 1'b0, "err_range");
        txn(0, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, "after_range");
        txn(0, 1'b1, 1'b1, 32'h20, 32'h0000_0099, 1'b0, "err_both");
        txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "after_both");

        txn(1, 1'b0, 1'b1, 32'h40, 32'h0000_CAFE, 1'b0, "lat0_store");
        txn(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, "lat0_load");
        txn(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, "lat0_held_load");
        txn(2, 1'b0, 1'b1, 32'h40, 32'h0000_BEEF, 1'b0, "lat5_store");
        txn(2, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, "lat5_load");

        // Reset during WAIT must drop the pending store and its ready
        txn(0, 1'b0, 1'b1, 32'h08, 32'h0000_5555, 1'b0, "store_08");
        @(negedge clk);
        mw[0] = 1'b1; ad[0] = 32'h08; wd[0] = 32'h0000_AAAA;
        @(posedge clk); #1;
        mw[0] = 1'b0; ad[0] = 32'h0; wd[0] = 32'h0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midop_reset_ready", 32'(rdy[0]), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            chk("midop_no_ready", 32'(rdy[0]), 32'h0);
        end
        txn(0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, "midop_load_08");

        for (int t = 0; t < 80; t++) begin
            k    = $urandom_range(0, 2);
            sel  = $urandom_range(0, 9);
            a    = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            r    = $urandom_range(0, 1) == 1;
            w    = !r;
            hold = $urandom_range(0, 3) == 0;
            if (sel == 7) a = a | 32'($urandom_range(1, 3));
            if (sel == 8) a = a | (32'h1 << $urandom_range(8, 31));
            if (sel == 9) begin
                r = 1'b1; w = 1'b1;
            end
            txn(k, r, w, a, $urandom, hold, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
